// File: rtl/freq_meas_sched.sv
// freq_meas_sched: round-robin scheduler that shares one frequency meter across NUM_CH test clocks,
// capturing a stable count per channel and keeping per-channel health flags.
module freq_meas_sched #(
    parameter int NUM_CH        = 4,
    parameter int GATE_CYCLES   = 100000,
    parameter int SETTLE_CYCLES = 32,
    parameter int MAX_RETRY     = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      run,
    input  logic                      start,
    input  logic [NUM_CH-1:0]         ch_mask,
    output logic [$clog2(NUM_CH)-1:0] fmeas_sel,
    output logic                      fmeas_enable,
    input  logic [23:0]               fmeas_count,
    output logic                      busy,
    output logic                      result_wr,
    output logic [$clog2(NUM_CH)-1:0] result_ch,
    output logic [23:0]               result_count,
    output logic [NUM_CH-1:0]         result_valid,
    output logic [NUM_CH-1:0]         stuck_zero,
    output logic [NUM_CH-1:0]         stuck_ones,
    output logic [NUM_CH-1:0]         unstable
);
    localparam int CW = $clog2(NUM_CH);
    localparam int WW = $clog2(GATE_CYCLES + SETTLE_CYCLES + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    typedef enum logic [2:0] {IDLE, SELECT, ARM, GATE, CAPTURE, WRITE, NEXT} state_t;

    state_t            r_state, w_state_nx;
    logic [CW-1:0]     r_ch, r_first, w_target, w_after;
    logic              r_pass, r_phase, w_wrapped, w_match, w_done;
    logic [WW-1:0]     r_cnt;
    logic [RW-1:0]     r_retry;
    logic [23:0]       r_samp, r_count;
    logic [NUM_CH-1:0] r_valid, r_zero, r_ones, r_unst;

    // Lowest enabled channel at offset >= skip from base, wrapping; base itself if none.
    function automatic logic [CW-1:0] f_pick(input logic [NUM_CH-1:0] m, input logic [CW-1:0] base, input int skip);
        logic [CW-1:0] v;
        logic [CW-1:0] idx;
        v = base;
        for (int k = NUM_CH - 1 + skip; k >= skip; k--) begin
            idx = CW'((int'(base) + k) % NUM_CH);
            if (m[idx]) v = idx;
        end
        return v;
    endfunction

    function automatic logic [CW-1:0] f_off(input logic [CW-1:0] c, input logic [CW-1:0] first);
        return CW'(c >= first ? int'(c) - int'(first) : int'(c) + NUM_CH - int'(first));
    endfunction

    always_comb begin
        w_target   = f_pick(ch_mask, r_ch, 0);
        w_after    = f_pick(ch_mask, r_ch, 1);
        w_wrapped  = f_off(w_after, r_first) <= f_off(r_ch, r_first);
        w_match    = fmeas_count == r_samp;
        w_done     = r_phase && (w_match || r_retry == RW'(MAX_RETRY));
        w_state_nx = r_state;
        case (r_state)
            IDLE:    w_state_nx = ((run || start) && |ch_mask) ? SELECT : IDLE;
            SELECT:  w_state_nx = (r_cnt == WW'(SETTLE_CYCLES - 1)) ? ARM : SELECT;
            ARM:     w_state_nx = GATE;
            GATE:    w_state_nx = (r_cnt == WW'(GATE_CYCLES + SETTLE_CYCLES - 1)) ? CAPTURE : GATE;
            CAPTURE: w_state_nx = w_done ? WRITE : CAPTURE;
            WRITE:   w_state_nx = NEXT;
            NEXT:    w_state_nx = (|ch_mask && (run || (r_pass && !w_wrapped))) ? SELECT : IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else r_state <= w_state_nx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ch    <= '0;
            r_first <= '0;
            r_pass  <= 1'b0;
            r_cnt   <= '0;
            r_retry <= '0;
            r_phase <= 1'b0;
            r_samp  <= '0;
            r_count <= '0;
            r_valid <= '0;
            r_zero  <= '0;
            r_ones  <= '0;
            r_unst  <= '0;
        end else begin
            r_cnt <= (r_state == w_state_nx && (r_state == SELECT || r_state == GATE)) ? r_cnt + 1'b1 : '0;
            if (r_state == IDLE && w_state_nx == SELECT) begin
                r_ch    <= w_target;
                r_first <= w_target;
                r_pass  <= !run;
            end
            if (r_state == NEXT && |ch_mask) r_ch <= w_after;
            // Samples are taken in pairs: phase 0 stores, phase 1 compares against the live count.
            if (r_state == CAPTURE) begin
                r_phase <= !r_phase;
                if (!r_phase) r_samp <= fmeas_count;
                else if (!w_done) r_retry <= r_retry + 1'b1;
                else begin
                    r_count      <= fmeas_count;
                    r_unst[r_ch] <= !w_match;
                end
            end else begin
                r_phase <= 1'b0;
                r_retry <= '0;
            end
            if (r_state == WRITE) begin
                r_valid[r_ch] <= 1'b1;
                r_zero[r_ch]  <= r_count == '0;
                r_ones[r_ch]  <= &r_count;
            end
        end
    end

    assign fmeas_sel    = r_ch;
    assign fmeas_enable = r_state == ARM;
    assign busy         = r_state != IDLE;
    assign result_wr    = r_state == WRITE;
    assign result_ch    = r_ch;
    assign result_count = r_count;
    assign result_valid = r_valid;
    assign stuck_zero   = r_zero;
    assign stuck_ones   = r_ones;
    assign unstable     = r_unst;
endmodule

// File: tb/tb_freq_meas_sched.sv
// tb_freq_meas_sched: randomized self-checking bench with a per-channel meter model and pass-level reference.
module tb_freq_meas_sched;
    localparam int N = 4, G = 200, S = 8, R = 3;
    localparam int P = G + 2 * S + 5;
    localparam logic [23:0] TA = 24'h001234, TB = 24'h001235;

    logic        clk = 0, reset = 1, run = 0, start = 0;
    logic [3:0]  ch_mask = 0;
    logic [23:0] fmeas_count = 0;
    logic [1:0]  fmeas_sel, result_ch;
    logic        fmeas_enable, busy, result_wr;
    logic [23:0] result_count;
    logic [3:0]  result_valid, stuck_zero, stuck_ones, unstable;

    always #5 clk = ~clk;

    freq_meas_sched #(.NUM_CH(N), .GATE_CYCLES(G), .SETTLE_CYCLES(S), .MAX_RETRY(R)) dut (
        .clk(clk), .reset(reset), .run(run), .start(start), .ch_mask(ch_mask),
        .fmeas_sel(fmeas_sel), .fmeas_enable(fmeas_enable), .fmeas_count(fmeas_count),
        .busy(busy), .result_wr(result_wr), .result_ch(result_ch), .result_count(result_count),
        .result_valid(result_valid), .stuck_zero(stuck_zero), .stuck_ones(stuck_ones), .unstable(unstable)
    );

    // Meter model: a fixed value per channel, or a count that changes every clock when toggling.
    logic [23:0] mv [N];
    logic [3:0]  tog = 0;
    logic        ph = 0;
    always @(negedge clk) begin
        ph = ~ph;
        fmeas_count = tog[fmeas_sel] ? (ph ? TA : TB) : mv[fmeas_sel];
    end

    int          cyc = 0, en_dbl = 0;
    logic        en_prev = 0;
    int          wq_ch[$], wq_cyc[$], en_cyc[$];
    logic [23:0] wq_cnt[$];
    always @(negedge clk) begin
        cyc++;
        if (result_wr) begin
            wq_ch.push_back(int'(result_ch));
            wq_cnt.push_back(result_count);
            wq_cyc.push_back(cyc);
        end
        if (fmeas_enable) begin
            en_cyc.push_back(cyc);
            if (en_prev) en_dbl++;
        end
        en_prev = fmeas_enable;
    end

    int   n_chk = 0, n_err = 0, mptr = 0;
    int   exp_q[$];
    logic [3:0] mvalid = 0, mzero = 0, mones = 0, munst = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        wq_ch.delete(); wq_cnt.delete(); wq_cyc.delete(); en_cyc.delete(); en_dbl = 0;
    endtask

    // Channels of one pass: every enabled channel, starting from the first at or after the pointer.
    task automatic build_list(input logic [3:0] m);
        exp_q.delete();
        for (int k = 0; k < N; k++) if (m[(mptr + k) % N]) exp_q.push_back((mptr + k) % N);
    endtask

    task automatic model_write(input int c);
        mvalid[c] = 1;
        munst[c]  = tog[c];
        mzero[c]  = !tog[c] && mv[c] == 24'h0;
        mones[c]  = !tog[c] && mv[c] == 24'hFFFFFF;
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, ".valid"}, result_valid, mvalid);
        chk({tag, ".zero"}, stuck_zero, mzero);
        chk({tag, ".ones"}, stuck_ones, mones);
        chk({tag, ".unst"}, unstable, munst);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".wr"}, result_wr, 0);
        chk({tag, ".en"}, fmeas_enable, 0);
        chk({tag, ".sel"}, fmeas_sel, 0);
        chk({tag, ".rch"}, result_ch, 0);
        chk({tag, ".rcnt"}, result_count, 0);
        chk_flags(tag);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 5000) begin
            n++;
            @(negedge clk);
        end
        if (busy) chk("idle_timeout", busy, 0);
    endtask

    task automatic chk_writes(input string tag);
        chk({tag, ".n_writes"}, wq_ch.size(), exp_q.size());
        for (int i = 0; i < wq_ch.size() && i < exp_q.size(); i++) begin
            int c;
            c = exp_q[i];
            chk($sformatf("%s.ch%0d", tag, i), wq_ch[i], c);
            if (tog[c]) chk($sformatf("%s.tog%0d", tag, i), int'(wq_cnt[i] == TA || wq_cnt[i] == TB), 1);
            else chk($sformatf("%s.cnt%0d", tag, i), wq_cnt[i], mv[c]);
            if (i > 0) chk($sformatf("%s.gap%0d", tag, i), wq_cyc[i] - wq_cyc[i-1], P + (tog[c] ? 2 * R : 0));
            model_write(c);
        end
    endtask

    task automatic run_pass(input string tag, input logic [3:0] m);
        int n, eb;
        @(negedge clk);
        ch_mask = m;
        build_list(m);
        clear_q();
        pulse_start();
        wait_idle(n);
        eb = 0;
        foreach (exp_q[i]) eb += P + (tog[exp_q[i]] ? 2 * R : 0);
        chk({tag, ".busy_cycles"}, n, eb);
        chk_writes(tag);
        if (exp_q.size() > 0) mptr = exp_q[0];
        chk_flags(tag);
    endtask

    initial begin
        int n, t, sel_bad;
        for (int c = 0; c < N; c++) mv[c] = 24'd5000;
        repeat (3) @(negedge clk);
        chk_zero_outputs("rst_hold");
        reset = 0;
        @(negedge clk);
        chk_zero_outputs("rst_rel");

        run_pass("pass1011", 4'b1011);

        mv[1] = 24'h0; mv[3] = 24'hFFFFFF;
        run_pass("stuck", 4'b1010);
        chk("stuck.zero_dir", stuck_zero, 4'b0010);
        chk("stuck.ones_dir", stuck_ones, 4'b1000);
        mv[1] = 24'd5000; mv[3] = 24'd5000;
        run_pass("unstuck", 4'b1010);

        for (int it = 0; it < 6; it++) begin
            logic [3:0] m;
            for (int c = 0; c < N; c++) begin
                int r;
                r = $urandom_range(0, 3);
                mv[c] = r == 0 ? 24'h0 : r == 1 ? 24'hFFFFFF : 24'($urandom_range(1, 24'hFFFFFE));
            end
            m = 4'($urandom_range(1, 15));
            run_pass($sformatf("rnd%0d", it), m);
        end
        for (int c = 0; c < N; c++) mv[c] = 24'($urandom_range(1, 24'hFFFFFE));

        // Continuous run on a single channel, dropped right after the third result.
        @(negedge clk);
        ch_mask = 4'b0100;
        clear_q();
        run = 1;
        n = 0; t = 0; sel_bad = 0;
        while (n < 3 && t < 3000) begin
            @(negedge clk);
            t++;
            if (busy && fmeas_sel != 2) sel_bad++;
            if (result_wr) n++;
        end
        run = 0;
        chk("run1.reached3", n, 3);
        wait_idle(t);
        exp_q = '{2, 2, 2};
        chk_writes("run1");
        chk("run1.sel_bad", sel_bad, 0);
        chk("run1.n_en", en_cyc.size(), 3);
        for (int i = 1; i < en_cyc.size(); i++) chk($sformatf("run1.en_gap%0d", i), en_cyc[i] - en_cyc[i-1], P);
        chk("run1.en_dbl", en_dbl, 0);
        mptr = 2;
        chk_flags("run1");

        // Run dropped while channel 1 is gating: channel 1 still completes, channel 2 is not started.
        @(negedge clk);
        ch_mask = 4'b0111;
        build_list(4'b0111);
        while (exp_q.size() > 0 && exp_q[exp_q.size()-1] != 1) void'(exp_q.pop_back());
        clear_q();
        run = 1;
        t = 0;
        while (!(fmeas_enable && fmeas_sel == 1) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("drop.arm1_seen", int'(fmeas_enable && fmeas_sel == 1), 1);
        @(negedge clk) run = 0;
        wait_idle(t);
        chk_writes("drop");
        mptr = 2;
        chk_flags("drop");

        // Channel 0 count changes every cycle: all retries are spent, then a stable pass clears the flag.
        tog[0] = 1;
        run_pass("tog", 4'b0001);
        chk("tog.unst0", unstable[0], 1);
        tog[0] = 0;
        run_pass("stable", 4'b0001);
        chk("stable.unst0", unstable[0], 0);

        // Reset during CAPTURE aborts with no result and clears every flag.
        @(negedge clk);
        ch_mask = 4'b0001;
        clear_q();
        pulse_start();
        t = 0;
        while (!fmeas_enable && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("rcap.arm_seen", fmeas_enable, 1);
        repeat (G + S + 1) @(negedge clk);
        chk("rcap.in_capture", int'(busy && !result_wr), 1);
        reset = 1;
        mvalid = 0; mzero = 0; mones = 0; munst = 0; mptr = 0;
        @(negedge clk);
        chk_zero_outputs("rcap");
        reset = 0;
        repeat (2) @(negedge clk);
        chk("rcap.no_wr", wq_ch.size(), 0);

        ch_mask = 4'b0000;
        pulse_start();
        n = 0;
        repeat (20) @(negedge clk) if (busy) n++;
        chk("mask0.busy", n, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
